// File: rtl/cdc_rx_gearbox.sv
// cdc_rx_gearbox: B-domain consumer on the CDC FIFO receive side.
// Drains the FIFO peek interface one word per cycle and packs Ratio narrow
// words into one wide word (lane 0 = first word, in the LSBs). Partial words
// leave through an explicit flush or an idle-timeout auto-flush, and
// OutCount_DB says how many lanes are valid.
//
// Handshakes:
//   input : a word moves when InValid_DB & InDeq_DB; InDeq_DB is combinational
//           and never asserted without InValid_DB or while rst is high.
//   output: a wide word moves when OutValid_DB & OutReady_DB; while
//           OutValid_DB=1 and OutReady_DB=0, OutData_DB/OutCount_DB hold.
//
// Ratio must be at least 2.
module cdc_rx_gearbox #(
  parameter int DataWidth     = 32,
  parameter int Ratio         = 4,
  parameter int TimeoutCycles = 0
) (
  input  logic                           clk_DB,
  input  logic                           rst,
  input  logic                           InValid_DB,
  input  logic [DataWidth-1:0]           InData_DB,
  output logic                           InDeq_DB,
  input  logic                           Flush_DB,
  output logic                           OutValid_DB,
  input  logic                           OutReady_DB,
  output logic [DataWidth*Ratio-1:0]     OutData_DB,
  output logic [$clog2(Ratio+1)-1:0]     OutCount_DB
);

  localparam int FW = $clog2(Ratio + 1);
  localparam int WW = DataWidth * Ratio;
  localparam int IW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  localparam logic [FW-1:0] FILL_FULL = FW'(Ratio);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TimeoutCycles);

  // Assembly state
  logic [FW-1:0] fill;
  logic [WW-1:0] asm_q;
  logic          flush_pend;
  logic [IW-1:0] idle_cnt;

  // Per-cycle decisions
  logic          accept;
  logic [FW-1:0] eff_fill;
  logic [WW-1:0] asm_next;
  logic          out_free;
  logic          timeout_hit;
  logic          flush_trig;
  logic          word_full;
  logic          emit_want;
  logic          load;

  // Accept while there is room and no flush is waiting for the output slot;
  // a pending flush freezes the assembly so the flushed word stays exact.
  assign accept   = InValid_DB & ~rst & (fill < FILL_FULL) & ~flush_pend;
  assign InDeq_DB = accept;

  assign eff_fill    = fill + {{(FW-1){1'b0}}, accept};
  assign out_free    = ~OutValid_DB | OutReady_DB;
  assign timeout_hit = (TimeoutCycles != 0) && (idle_cnt == IDLE_MAX);
  assign flush_trig  = Flush_DB | timeout_hit | flush_pend;
  assign word_full   = (eff_fill == FILL_FULL);
  assign emit_want   = word_full | (flush_trig & (eff_fill != '0));
  assign load        = emit_want & out_free;

  // Write the accepted word into the lane selected by the current fill level
  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < Ratio; i++) begin
      if (accept && (fill == FW'(i))) begin
        asm_next[i*DataWidth +: DataWidth] = InData_DB;
      end
    end
  end

  // Assembly register, fill level and pending-flush flag
  always_ff @(posedge clk_DB or posedge rst) begin
    if (rst) begin
      fill       <= '0;
      asm_q      <= '0;
      flush_pend <= 1'b0;
    end else if (load) begin
      // Word leaves this edge; clearing the assembly keeps unused lanes zero.
      fill       <= '0;
      asm_q      <= '0;
      flush_pend <= 1'b0;
    end else begin
      fill       <= eff_fill;
      asm_q      <= asm_next;
      // An empty assembly never keeps a flush pending.
      flush_pend <= flush_trig & (eff_fill != '0);
    end
  end

  // Idle counter: cycles holding a partial word without accepting, saturating
  always_ff @(posedge clk_DB or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (load || accept) begin
      idle_cnt <= '0;
    end else if ((TimeoutCycles != 0) && (fill != '0) && (idle_cnt != IDLE_MAX)) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  // Registered output word: load when free, drop valid after a handshake
  always_ff @(posedge clk_DB or posedge rst) begin
    if (rst) begin
      OutValid_DB <= 1'b0;
      OutData_DB  <= '0;
      OutCount_DB <= '0;
    end else if (load) begin
      OutValid_DB <= 1'b1;
      OutData_DB  <= asm_next;
      OutCount_DB <= eff_fill;
    end else if (OutReady_DB) begin
      OutValid_DB <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdc_rx_gearbox.sv
// Bench for cdc_rx_gearbox (DataWidth=8, Ratio=4, TimeoutCycles=5).
// A free-running monitor keeps a word-level reference model: accepted bytes
// are grouped four at a time, or closed early by a flush or an idle timeout,
// and every output handshake is checked against the expected queue.
module tb_cdc_rx_gearbox;

  localparam int DW = 8;
  localparam int RT = 4;
  localparam int TO = 5;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          deq;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [2:0]    out_count;

  int n_checks = 0;
  int n_fail   = 0;

  cdc_rx_gearbox #(
    .DataWidth(DW),
    .Ratio(RT),
    .TimeoutCycles(TO)
  ) dut (
    .clk_DB(clk),
    .rst(rst),
    .InValid_DB(in_valid),
    .InData_DB(in_data),
    .InDeq_DB(deq),
    .Flush_DB(flush),
    .OutValid_DB(out_valid),
    .OutReady_DB(out_ready),
    .OutData_DB(out_data),
    .OutCount_DB(out_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model + scoreboard
  logic [34:0]   exp_q[$];
  logic [DW-1:0] cur_q[$];
  int            idle_m = 0;
  logic          hold_prev = 1'b0;
  logic [31:0]   prev_data;
  logic [2:0]    prev_count;

  task automatic close_group();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < cur_q.size(); i++) w[i*DW +: DW] = cur_q[i];
    exp_q.push_back({3'(cur_q.size()), w});
    cur_q.delete();
  endtask

  always begin
    logic [34:0] e;
    logic        trig;
    logic        closed;
    @(negedge clk);
    #3;
    if (rst) begin
      check("deq_in_reset", deq, 0);
      cur_q.delete();
      exp_q.delete();
      idle_m    = 0;
      hold_prev = 1'b0;
    end else begin
      if (!in_valid) check("deq_without_valid", deq, 0);
      if (hold_prev) begin
        check("hold_data", out_data, prev_data);
        check("hold_count", out_count, prev_count);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", out_data, e[31:0]);
          check("sb_count", out_count, e[34:32]);
        end
      end
      hold_prev  = out_valid && !out_ready;
      prev_data  = out_data;
      prev_count = out_count;
      if (deq) cur_q.push_back(in_data);
      trig   = flush || (idle_m >= TO);
      closed = 1'b0;
      if (cur_q.size() == RT || (trig && cur_q.size() > 0)) begin
        close_group();
        closed = 1'b1;
      end
      if (closed || deq) idle_m = 0;
      else if (cur_q.size() > 0 && idle_m < TO) idle_m++;
    end
  end

  // driver tasks
  task automatic send_word(input logic [DW-1:0] d);
    logic got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 60 && !got; t++) begin
      #1;
      got = deq;
      @(negedge clk);
    end
    check("send_accepted", got, 1);
  endtask

  task automatic wait_drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_empty", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // table vectors
  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          f;
    logic          r;
    logic          e_deq;
    logic          e_ov;
    logic [31:0]   e_data;
    logic [2:0]    e_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input logic [DW-1:0] d, input logic f, input logic r,
                     input logic edq, input logic eov, input logic [31:0] ed, input logic [2:0] ec);
    vec_t x;
    x.v = v; x.d = d; x.f = f; x.r = r;
    x.e_deq = edq; x.e_ov = eov; x.e_data = ed; x.e_cnt = ec;
    tbl.push_back(x);
  endtask

  initial begin
    logic got;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_deq", deq, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    // basic pack, streaming, flush, flush on empty, accept+flush
    add(1, 8'h11, 0, 1, 1, 0, 0, 0);
    add(1, 8'h22, 0, 1, 1, 0, 0, 0);
    add(1, 8'h33, 0, 1, 1, 0, 0, 0);
    add(1, 8'h44, 0, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 32'h44332211, 4);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      add(1, 8'(k), 0, 1, 1, (k == 5), (k == 5) ? 32'h04030201 : 32'h0, (k == 5) ? 3'd4 : 3'd0);
    add(0, 8'h00, 0, 1, 0, 1, 32'h08070605, 4);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0);
    add(1, 8'hAA, 0, 1, 1, 0, 0, 0);
    add(1, 8'hBB, 0, 1, 1, 0, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 32'h0000BBAA, 2);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0);
    add(1, 8'hCC, 0, 1, 1, 0, 0, 0);
    add(1, 8'hDD, 1, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 32'h0000DDCC, 2);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      in_valid  = tbl[i].v;
      in_data   = tbl[i].d;
      flush     = tbl[i].f;
      out_ready = tbl[i].r;
      #1;
      check($sformatf("tbl%0d_deq", i), deq, tbl[i].e_deq);
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        check($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
        check($sformatf("tbl%0d_count", i), out_count, tbl[i].e_cnt);
      end
    end
    wait_drain();

    // backpressure: first word held, second fills, 9th word stalls
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k);
      #1;
      check("bp_deq", deq, 1);
      @(negedge clk);
    end
    in_data = 8'd9;
    for (int t = 0; t < 3; t++) begin
      #1;
      check("bp_stall_deq", deq, 0);
      check("bp_valid", out_valid, 1);
      check("bp_hold_data", out_data, 32'h04030201);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 9; k <= 12; k++) send_word(8'(k));
    wait_drain();

    // idle-timeout auto-flush of a single lane
    send_word(8'h5C);
    in_valid = 1'b0;
    for (int t = 0; t < TO; t++) begin
      #1;
      check("to_early_valid", out_valid, 0);
      @(negedge clk);
    end
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      #1;
      got = out_valid;
      if (!got) @(negedge clk);
    end
    check("to_fired", got, 1);
    check("to_data", out_data, 32'h0000005C);
    check("to_count", out_count, 1);
    wait_drain();

    // reset mid-word with an output held
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) send_word(8'h21 + 8'(k));
    in_valid = 1'b1;
    in_data  = 8'h28;
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_deq", deq, 0);
    @(negedge clk);
    #1;
    check("mid_rst_deq_hold", deq, 0);
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) send_word(8'h10 + 8'(k));
    in_valid = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      #1;
      got = out_valid;
      if (!got) @(negedge clk);
    end
    check("post_rst_valid", got, 1);
    check("post_rst_data", out_data, 32'h13121110);
    check("post_rst_count", out_count, 4);
    @(negedge clk);
    #1;
    check("post_rst_single", out_valid, 0);
    wait_drain();

    // randomized traffic against the reference model
    begin
      int gap;
      gap = 0;
      for (int c = 0; c < 800; c++) begin
        @(negedge clk);
        if (gap > 0) begin
          gap--;
          in_valid = 1'b0;
        end else begin
          in_valid = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 30) == 0) gap = $urandom_range(3, 9);
        end
        in_data   = 8'($urandom);
        flush     = ($urandom_range(0, 19) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
